// File: rtl/spi_arb_pkg.sv
// Shared definitions for the spictrl arbiter: FSM encoding, byte width and
// requester indices. Imported by the arbiter top, its picker and its interface.
package spi_arb_pkg;

   localparam int BYTE_W = 8;

   // Requester indices; the round-robin pointer holds the last one served.
   localparam logic REQ_HOST = 1'b0;
   localparam logic REQ_BOOT = 1'b1;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_GRANT   = 3'd1,
      ST_LAUNCH  = 3'd2,
      ST_XFER    = 3'd3,
      ST_DONE    = 3'd4,
      ST_RELEASE = 3'd5
   } state_t;

endpackage

// File: rtl/spi_arbiter_if.sv
// Bundle of requester-side and spictrl-side signals around the arbiter.
//   slave  : the arbiter (consumes locks/starts/busy, drives grants/dones/spi_*)
//   master : the environment (host requester, boot reader and spictrl)
interface spi_arbiter_if;
   import spi_arb_pkg::*;

   logic              r0_lock,   r1_lock;
   logic              r0_start,  r1_start;
   logic [BYTE_W-1:0] r0_txdata, r1_txdata;
   logic              r0_slow,   r1_slow;
   logic              r0_grant,  r1_grant;
   logic              r0_done,   r1_done;
   logic [BYTE_W-1:0] rxdata;
   logic              timeout;
   logic [BYTE_W-1:0] spi_txdata;
   logic              spi_txstart;
   logic              spi_slow;
   logic [BYTE_W-1:0] spi_rxdata;
   logic              spi_busy;
   logic              spi_cs_n;

   modport slave (
      input  r0_lock, r1_lock, r0_start, r1_start, r0_txdata, r1_txdata,
             r0_slow, r1_slow, spi_rxdata, spi_busy,
      output r0_grant, r1_grant, r0_done, r1_done, rxdata, timeout,
             spi_txdata, spi_txstart, spi_slow, spi_cs_n
   );

   modport master (
      output r0_lock, r1_lock, r0_start, r1_start, r0_txdata, r1_txdata,
             r0_slow, r1_slow, spi_rxdata, spi_busy,
      input  r0_grant, r1_grant, r0_done, r1_done, rxdata, timeout,
             spi_txdata, spi_txstart, spi_slow, spi_cs_n
   );

endinterface

// File: rtl/spi_arb_rr.sv
// Two-way round-robin picker.
//   eligible : lock requests that may be granted (bit 0 = host, bit 1 = boot)
//   ptr      : requester served last
//   grant    : one-hot winner, zero when nothing is eligible
//   ptr_next : pointer value to store if the grant is taken
module spi_arb_rr
   import spi_arb_pkg::*;
(
   input  logic [1:0] eligible,
   input  logic       ptr,
   output logic [1:0] grant,
   output logic       ptr_next
);

   // On a tie the requester not served last wins.
   always_comb begin
      grant    = 2'b00;
      ptr_next = ptr;
      if (eligible[0] && (!eligible[1] || ptr == REQ_BOOT)) begin
         grant    = 2'b01;
         ptr_next = REQ_HOST;
      end else if (eligible[1]) begin
         grant    = 2'b10;
         ptr_next = REQ_BOOT;
      end
   end

endmodule

// File: rtl/spi_arbiter.sv
// Shares one spictrl byte engine between the host register interface (r0)
// and the boot/flash reader (r1). The owner holds chip select for a
// multi-byte transaction and issues one byte per start.
//   clk  : system clock
//   rst  : asynchronous active-low reset
//   bus  : requester handshakes, shared rxdata/timeout, spictrl connection
//
// state   | meaning
// IDLE    | bus free, cs high, picking next owner
// GRANT   | owner holds cs, waiting for start / lock drop / idle timeout
// LAUNCH  | single cycle of spi_txstart
// XFER    | spictrl busy with the byte
// DONE    | capture rxdata, pulse owner's done
// RELEASE | cs high guard before the next owner
module spi_arbiter #(
   parameter int LOCK_TIMEOUT = 4095,
   parameter int CS_GUARD     = 2
) (
   input logic          clk,
   input logic          rst,
   spi_arbiter_if.slave bus
);
   import spi_arb_pkg::*;

   localparam int IDLE_W  = (LOCK_TIMEOUT < 1) ? 1 : $clog2(LOCK_TIMEOUT + 1);
   localparam int GUARD_W = (CS_GUARD < 1) ? 1 : $clog2(CS_GUARD + 1);
   localparam logic [IDLE_W-1:0]  IDLE_TC    = IDLE_W'(LOCK_TIMEOUT - 1);
   localparam logic [GUARD_W-1:0] GUARD_LOAD = GUARD_W'((CS_GUARD > 0) ? CS_GUARD - 1 : 0);

   state_t            state, state_nx;
   logic              owner, ptr, rr_ptr;
   logic [1:0]        lock, inelig, eligible, rr_grant;
   logic              owner_lock, owner_start, owner_slow;
   logic [BYTE_W-1:0] owner_txdata;
   logic              take_start, fire_timeout;
   logic [IDLE_W-1:0] idle_cnt;
   logic [GUARD_W-1:0] guard_cnt;
   logic [1:0]        grant_q, done_q;
   logic [BYTE_W-1:0] rxdata_q, txdata_q;
   logic              txstart_q, slow_q, timeout_q, cs_n_q;

   assign lock         = {bus.r1_lock, bus.r0_lock};
   assign eligible     = lock & ~inelig;
   assign owner_lock   = owner ? bus.r1_lock   : bus.r0_lock;
   assign owner_start  = owner ? bus.r1_start  : bus.r0_start;
   assign owner_slow   = owner ? bus.r1_slow   : bus.r0_slow;
   assign owner_txdata = owner ? bus.r1_txdata : bus.r0_txdata;

   spi_arb_rr u_rr (
      .eligible (eligible),
      .ptr      (ptr),
      .grant    (rr_grant),
      .ptr_next (rr_ptr)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= ST_IDLE;
      else      state <= state_nx;
   end

   // Starts are only looked at in GRANT and only from the owner, so a
   // foreign or early start has no effect at all.
   always_comb begin
      state_nx     = state;
      take_start   = 1'b0;
      fire_timeout = 1'b0;
      case (state)
         ST_IDLE:    if (|rr_grant) state_nx = ST_GRANT;
         ST_GRANT: begin
            if (owner_start) begin
               take_start = 1'b1;
               state_nx   = ST_LAUNCH;
            end else if (!owner_lock) begin
               state_nx = ST_RELEASE;
            end else if (idle_cnt == IDLE_TC) begin
               fire_timeout = 1'b1;
               state_nx     = ST_RELEASE;
            end
         end
         ST_LAUNCH:  state_nx = ST_XFER;
         ST_XFER:    if (!bus.spi_busy) state_nx = ST_DONE;
         ST_DONE:    state_nx = owner_lock ? ST_GRANT : ST_RELEASE;
         ST_RELEASE: if (guard_cnt == '0) state_nx = ST_IDLE;
         default:    state_nx = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         owner     <= REQ_HOST;
         ptr       <= REQ_BOOT;
         inelig    <= 2'b00;
         grant_q   <= 2'b00;
         done_q    <= 2'b00;
         rxdata_q  <= '0;
         txdata_q  <= '0;
         txstart_q <= 1'b0;
         slow_q    <= 1'b0;
         timeout_q <= 1'b0;
         cs_n_q    <= 1'b1;
         idle_cnt  <= '0;
         guard_cnt <= GUARD_LOAD;
      end else begin
         done_q    <= 2'b00;
         txstart_q <= take_start;
         timeout_q <= fire_timeout;
         // A timed-out requester stays blocked until its lock is seen low.
         inelig <= inelig & lock;
         if (fire_timeout) inelig[owner] <= 1'b1;
         if (state == ST_IDLE && |rr_grant) begin
            owner   <= rr_grant[1];
            ptr     <= rr_ptr;
            grant_q <= rr_grant;
            cs_n_q  <= 1'b0;
         end
         if (state_nx == ST_RELEASE && state != ST_RELEASE) begin
            grant_q <= 2'b00;
            cs_n_q  <= 1'b1;
         end
         if (take_start) begin
            txdata_q <= owner_txdata;
            slow_q   <= owner_slow;
         end
         if (state == ST_DONE) begin
            done_q[owner] <= 1'b1;
            rxdata_q      <= bus.spi_rxdata;
         end
         // Zero outside GRANT, so entry to GRANT always starts from zero.
         idle_cnt  <= (state == ST_GRANT && !take_start) ? idle_cnt + 1'b1 : '0;
         guard_cnt <= (state != ST_RELEASE) ? GUARD_LOAD :
                      (guard_cnt != '0) ? guard_cnt - 1'b1 : guard_cnt;
      end
   end

   assign bus.r0_grant    = grant_q[0];
   assign bus.r1_grant    = grant_q[1];
   assign bus.r0_done     = done_q[0];
   assign bus.r1_done     = done_q[1];
   assign bus.rxdata      = rxdata_q;
   assign bus.timeout     = timeout_q;
   assign bus.spi_txdata  = txdata_q;
   assign bus.spi_txstart = txstart_q;
   assign bus.spi_slow    = slow_q;
   assign bus.spi_cs_n    = cs_n_q;

endmodule
